qupls_checkpoint_valid_file: RTL and testbench

Multi-ported store of one physical-register valid bit per register per rename checkpoint. It sits beside the rename map. Writeback and rename ports update valid bits, and operand-readiness lookups read them. It is the parametrised successor of the fixed 8-write/16-read checkpoint valid RAM and adds three behaviours:
- a hardware initialisation sweep after reset;
- a background checkpoint-copy engine for branch checkpoint allocation;
- same-cycle write-to-read bypass.

---
 rtl/qupls_checkpoint_valid_file.sv | 155 +++++++++++++++
 tb/tb_qupls_checkpoint_valid_file.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/qupls_checkpoint_valid_file.sv
// Per-checkpoint physical-register valid bits with multi-port write/read,
// a post-reset init sweep, a background checkpoint-copy engine and write-to-read bypass.
module qupls_checkpoint_valid_file #(
  parameter int NPORT   = 4,
  parameter int NRDPORT = 8,
  parameter int NCHECK  = 16,
  parameter int PREGS   = 256,
  parameter int SWEEP_W = 8,
  localparam int CPW = $clog2(NCHECK),
  localparam int PRW = $clog2(PREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORT-1:0]       wr,
  input  logic [NPORT*CPW-1:0]   wc,
  input  logic [NPORT*PRW-1:0]   wa,
  input  logic [NPORT-1:0]       i,
  input  logic [NRDPORT*CPW-1:0] rc,
  input  logic [NRDPORT*PRW-1:0] ra,
  output logic [NRDPORT-1:0]     o,
  input  logic                   cp_req,
  input  logic [CPW-1:0]         cp_src,
  input  logic [CPW-1:0]         cp_dst,
  output logic                   cp_ack,
  output logic                   cp_done,
  output logic                   busy,
  output logic                   init_done
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_COPY = 2'd2
  } state_t;

  localparam logic [PRW-1:0] LAST_PTR = PRW'(PREGS - SWEEP_W);
  localparam logic [PRW-1:0] STEP     = PRW'(SWEEP_W);

  state_t                         state_q, state_d;
  logic [PRW-1:0]                 ptr_q, ptr_d;
  logic [CPW-1:0]                 src_q, src_d;
  logic [CPW-1:0]                 dst_q, dst_d;
  logic                           init_done_q, init_done_d;
  logic [NRDPORT-1:0]             o_q, o_d;
  logic [NCHECK-1:0][PREGS-1:0]   mem_q, mem_d;
  logic                           last_grp;

  assign last_grp  = (ptr_q == LAST_PTR);
  assign busy      = (state_q != ST_IDLE);
  assign init_done = init_done_q;
  assign o         = o_q;

  // NOTE: combinational next-state logic uses blocking assignments so that later
  // statements (higher-numbered ports) override earlier ones within the same cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    src_d       = src_q;
    dst_d       = dst_q;
    init_done_d = init_done_q;
    mem_d       = mem_q;
    cp_ack      = 1'b0;
    cp_done     = 1'b0;

    case (state_q)
      ST_INIT: begin
        for (int j = 0; j < SWEEP_W; j++) begin
          for (int c = 0; c < NCHECK; c++) begin
            mem_d[c][ptr_q + PRW'(j)] = 1'b1;
          end
        end
        ptr_d = ptr_q + STEP;
        if (last_grp) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (cp_req) begin
          cp_ack = 1'b1;
          if (cp_src == cp_dst) begin
            cp_done = 1'b1;
          end else begin
            src_d   = cp_src;
            dst_d   = cp_dst;
            ptr_d   = '0;
            state_d = ST_COPY;
          end
        end
      end
      ST_COPY: begin
        for (int j = 0; j < SWEEP_W; j++) begin
          mem_d[dst_q][ptr_q + PRW'(j)] = mem_q[src_q][ptr_q + PRW'(j)];
        end
        ptr_d = ptr_q + STEP;
        if (last_grp) begin
          cp_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase

    // Port writes land after the copy engine so they win over it; a write to the
    // copy source is mirrored into the destination in port order.
    if (state_q != ST_INIT) begin
      for (int n = 0; n < NPORT; n++) begin
        if (wr[n]) begin
          mem_d[wc[n*CPW +: CPW]][wa[n*PRW +: PRW]] = i[n];
          if (state_q == ST_COPY && wc[n*CPW +: CPW] == src_q) begin
            mem_d[dst_q][wa[n*PRW +: PRW]] = i[n];
          end
        end
      end
    end

    // Reading the next-state image gives bypass of every write made this cycle.
    for (int k = 0; k < NRDPORT; k++) begin
      o_d[k] = (state_q == ST_INIT) ? 1'b1 : mem_d[rc[k*CPW +: CPW]][ra[k*PRW +: PRW]];
    end

    if (!rst_n) begin
      cp_ack  = 1'b0;
      cp_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      init_done_q <= 1'b0;
      o_q         <= '1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      init_done_q <= init_done_d;
      o_q         <= o_d;
    end
  end

  // NOTE: the storage array has no reset; the init sweep writes every bit and
  // reads are forced to 1 until it finishes.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_qupls_checkpoint_valid_file.sv
// Directed bench for qupls_checkpoint_valid_file: init sweep, port priority,
// bypass, checkpoint copy with concurrent writes, backpressure and mid-copy reset.
module tb_qupls_checkpoint_valid_file;

  localparam int NPORT   = 4;
  localparam int NRDPORT = 8;
  localparam int NCHECK  = 16;
  localparam int PREGS   = 256;
  localparam int SWEEP_W = 8;
  localparam int CPW     = 4;
  localparam int PRW     = 8;
  localparam int NGRP    = PREGS / SWEEP_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NPORT-1:0]       wr;
  logic [NPORT*CPW-1:0]   wc;
  logic [NPORT*PRW-1:0]   wa;
  logic [NPORT-1:0]       i;
  logic [NRDPORT*CPW-1:0] rc;
  logic [NRDPORT*PRW-1:0] ra;
  logic [NRDPORT-1:0]     o;
  logic                   cp_req;
  logic [CPW-1:0]         cp_src;
  logic [CPW-1:0]         cp_dst;
  logic                   cp_ack;
  logic                   cp_done;
  logic                   busy;
  logic                   init_done;

  int errors = 0;
  int checks = 0;

  qupls_checkpoint_valid_file #(
    .NPORT(NPORT), .NRDPORT(NRDPORT), .NCHECK(NCHECK), .PREGS(PREGS), .SWEEP_W(SWEEP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .wc(wc), .wa(wa), .i(i), .rc(rc), .ra(ra), .o(o),
    .cp_req(cp_req), .cp_src(cp_src), .cp_dst(cp_dst), .cp_ack(cp_ack), .cp_done(cp_done),
    .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int n, input int c, input int a, input logic d);
    wr[n]              = 1'b1;
    wc[n*CPW +: CPW]   = CPW'(c);
    wa[n*PRW +: PRW]   = PRW'(a);
    i[n]               = d;
  endtask

  task automatic set_r(input int k, input int c, input int a);
    rc[k*CPW +: CPW] = CPW'(c);
    ra[k*PRW +: PRW] = PRW'(a);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (o !== 8'hFF) begin errors++; $display("FAIL reset_o got=%h exp=ff", o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if ({cp_ack, cp_done} !== 2'b00) begin errors++; $display("FAIL reset_cp got=%b exp=00", {cp_ack, cp_done}); end
  endtask

  task automatic test_init();
    set_r(0, 5, 200);
    rst_n = 1'b1;
    for (int k = 1; k <= NGRP; k++) begin
      if (k == 10) set_w(0, 5, 0, 1'b0);
      cp_req = (k == 12);
      step();
      wr = '0;
      cp_req = 1'b0;
      checks++; if (busy !== (k < NGRP)) begin errors++; $display("FAIL init_busy k=%0d got=%b exp=%b", k, busy, k < NGRP); end
      checks++; if (init_done !== (k == NGRP)) begin errors++; $display("FAIL init_done k=%0d got=%b exp=%b", k, init_done, k == NGRP); end
      checks++; if (o[0] !== 1'b1) begin errors++; $display("FAIL init_read k=%0d got=%b exp=1", k, o[0]); end
    end
    set_r(0, 5, 200);
    set_r(1, 5, 0);
    step();
    checks++; if (o[1:0] !== 2'b11) begin errors++; $display("FAIL init_post_read got=%b exp=11", o[1:0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_ignored_req busy=%b exp=0", busy); end
  endtask

  task automatic test_write_priority();
    set_w(0, 2, 17, 1'b1);
    set_w(3, 2, 17, 1'b0);
    set_w(1, 2, 18, 1'b0);
    set_w(2, 2, 18, 1'b1);
    set_r(1, 2, 17);
    set_r(7, 2, 18);
    step();
    wr = '0;
    checks++; if (o[1] !== 1'b0) begin errors++; $display("FAIL bypass_prio_17 got=%b exp=0", o[1]); end
    checks++; if (o[7] !== 1'b1) begin errors++; $display("FAIL bypass_prio_18 got=%b exp=1", o[7]); end
    set_r(0, 2, 19);
    step();
    checks++; if (o[1] !== 1'b0) begin errors++; $display("FAIL read_prio_17 got=%b exp=0", o[1]); end
    checks++; if (o[7] !== 1'b1) begin errors++; $display("FAIL read_prio_18 got=%b exp=1", o[7]); end
    checks++; if (o[0] !== 1'b1) begin errors++; $display("FAIL read_untouched got=%b exp=1", o[0]); end
    set_w(2, 9, 50, 1'b0);
    set_r(3, 9, 51);
    step();
    wr = '0;
    set_r(3, 9, 50);
    step();
    checks++; if (o[3] !== 1'b0) begin errors++; $display("FAIL write_then_read got=%b exp=0", o[3]); end
    set_w(1, 9, 50, 1'b1);
    set_r(3, 9, 51);
    step();
    wr = '0;
    set_r(3, 9, 50);
    step();
    checks++; if (o[3] !== 1'b1) begin errors++; $display("FAIL rewrite_then_read got=%b exp=1", o[3]); end
  endtask

  task automatic test_copy();
    for (int n = 0; n < NPORT; n++) set_w(n, 1, n, 1'b0);
    step();
    for (int n = 0; n < NPORT; n++) set_w(n, 1, n + 4, 1'b0);
    step();
    wr = '0;
    cp_req = 1'b1; cp_src = 4'd1; cp_dst = 4'd4;
    #1;
    checks++; if ({cp_ack, cp_done} !== 2'b10) begin errors++; $display("FAIL copy_ack got=%b exp=10", {cp_ack, cp_done}); end
    step();
    cp_req = 1'b0;
    for (int c = 1; c <= NGRP; c++) begin
      #1;
      checks++; if (busy !== 1'b1 || cp_done !== (c == NGRP)) begin
        errors++; $display("FAIL copy_progress c=%0d busy=%b done=%b exp busy=1 done=%b", c, busy, cp_done, c == NGRP);
      end
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL copy_busy_fall got=%b exp=0", busy); end
    set_r(0, 4, 3);   set_r(1, 4, 100); set_r(2, 4, 7); set_r(3, 4, 8);
    set_r(4, 1, 3);   set_r(5, 4, 0);   set_r(6, 3, 3); set_r(7, 1, 8);
    step();
    checks++; if (o !== 8'hCA) begin errors++; $display("FAIL copy_result got=%h exp=ca", o); end
  endtask

  task automatic test_copy_concurrent();
    cp_req = 1'b1; cp_src = 4'd2; cp_dst = 4'd6;
    #1;
    checks++; if (cp_ack !== 1'b1) begin errors++; $display("FAIL conc_ack got=%b exp=1", cp_ack); end
    step();
    cp_req = 1'b0;
    for (int c = 1; c <= NGRP; c++) begin
      if (c == 2) begin set_w(0, 2, 250, 1'b0); set_w(1, 6, 8, 1'b0); end
      if (c == 5) begin
        set_w(0, 2, 1, 1'b1); set_w(2, 6, 1, 1'b0);
        set_w(1, 6, 2, 1'b0); set_w(3, 2, 2, 1'b1);
      end
      if (c == 10) set_w(0, 2, 20, 1'b0);
      if (c == NGRP) set_r(0, 6, 250);
      step();
      wr = '0;
    end
    checks++; if (o[0] !== 1'b0) begin errors++; $display("FAIL conc_engine_bypass got=%b exp=0", o[0]); end
    set_r(0, 6, 250); set_r(1, 6, 8); set_r(2, 6, 17); set_r(3, 6, 20);
    set_r(4, 6, 1);   set_r(5, 6, 2); set_r(6, 2, 8);  set_r(7, 6, 100);
    step();
    checks++; if (o !== 8'hE0) begin errors++; $display("FAIL conc_result got=%h exp=e0", o); end
  endtask

  task automatic test_degenerate_backpressure();
    cp_req = 1'b1; cp_src = 4'd3; cp_dst = 4'd3;
    #1;
    checks++; if ({cp_ack, cp_done, busy} !== 3'b110) begin errors++; $display("FAIL degen got=%b exp=110", {cp_ack, cp_done, busy}); end
    step();
    cp_req = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL degen_busy got=%b exp=0", busy); end
    cp_req = 1'b1; cp_src = 4'd0; cp_dst = 4'd7;
    #1;
    checks++; if (cp_ack !== 1'b1) begin errors++; $display("FAIL bp_first_ack got=%b exp=1", cp_ack); end
    step();
    for (int c = 1; c <= NGRP; c++) begin
      #1;
      checks++; if (cp_ack !== 1'b0 || cp_done !== (c == NGRP)) begin
        errors++; $display("FAIL bp_hold c=%0d ack=%b done=%b exp ack=0 done=%b", c, cp_ack, cp_done, c == NGRP);
      end
      step();
    end
    #1;
    checks++; if ({cp_ack, busy} !== 2'b10) begin errors++; $display("FAIL bp_reack got=%b exp=10", {cp_ack, busy}); end
    step();
    cp_req = 1'b0;
  endtask

  task automatic test_reset_mid_copy();
    for (int c = 1; c <= 10; c++) begin
      #1;
      checks++; if (busy !== 1'b1 || cp_done !== 1'b0) begin errors++; $display("FAIL rmc_copy c=%0d busy=%b done=%b exp 1 0", c, busy, cp_done); end
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (cp_done !== 1'b0) begin errors++; $display("FAIL rmc_no_done got=%b exp=0", cp_done); end
    step();
    rst_n = 1'b1;
    checks++; if ({busy, init_done} !== 2'b10) begin errors++; $display("FAIL rmc_reinit got=%b exp=10", {busy, init_done}); end
    for (int k = 1; k <= NGRP; k++) begin
      step();
      checks++; if (cp_done !== 1'b0) begin errors++; $display("FAIL rmc_init_done_pulse k=%0d got=%b exp=0", k, cp_done); end
    end
    checks++; if ({busy, init_done} !== 2'b01) begin errors++; $display("FAIL rmc_init_end got=%b exp=01", {busy, init_done}); end
    set_r(0, 1, 3); set_r(1, 2, 17); set_r(2, 6, 8);  set_r(3, 6, 250);
    set_r(4, 4, 3); set_r(5, 9, 50); set_r(6, 7, 5);  set_r(7, 15, 128);
    step();
    checks++; if (o !== 8'hFF) begin errors++; $display("FAIL rmc_all_ones got=%h exp=ff", o); end
  endtask

  initial begin
    wr = '0; wc = '0; wa = '0; i = '0; rc = '0; ra = '0;
    cp_req = 1'b0; cp_src = '0; cp_dst = '0;
    test_reset();
    test_init();
    test_write_priority();
    test_copy();
    test_copy_concurrent();
    test_degenerate_backpressure();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
